// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch target buffer: counter encoding, entry layout, sizing.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
package branch_predictor_pkg;

  localparam int BTB_ENTRIES = 16;
  localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_W   = 30 - BTB_IDX_W;

  typedef logic [31:0] word_t;

  // Two-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // Entry layout for the default 16-entry table.
  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    word_t                target;
    bp_ctr_t              ctr;
  } btb_entry_t;

  // Sequential fall-through address, wraps at 32 bits.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Next-state logic for a 2-bit saturating direction counter.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ctr (current state), taken (resolved direction), ctr_next (stepped state).
module branch_predictor_sat_ctr2
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    case (ctr)
      SNT:     ctr_next = taken ? WNT : SNT;
      WNT:     ctr_next = taken ? WT  : SNT;
      WT:      ctr_next = taken ? ST  : WNT;
      ST:      ctr_next = taken ? ST  : WT;
      default: ctr_next = SNT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters plus lookup/mispredict statistics.
// Latency: lookup is combinational off the registered table; updates visible next cycle.
// Backpressure: none; every lookup and update is accepted in the cycle presented.
// Ports: CLK/nRST; lookup_en/lookup_pc -> predict_taken/predict_target;
//        update_en/update_pc/update_taken/update_target/update_mispredict; clear;
//        lookup_count/mispredict_count (saturating statistics).
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  input  logic        clear,
  output logic [31:0] lookup_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  word_t            target_q [ENTRIES];
  bp_ctr_t          ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  bp_ctr_t          ctr_next;

  // Byte offset bits never participate in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[31:IDX_W+2];

  // Lookup reads the table as registered: a same-cycle update is not bypassed.
  assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predict_taken  = lk_hit && ctr_q[lk_idx][1];
  assign predict_target = predict_taken ? target_q[lk_idx] : pc_plus4(lookup_pc);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  branch_predictor_sat_ctr2 u_sat_ctr2 (
    .ctr      (ctr_q[up_idx]),
    .taken    (update_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= SNT;
      end
    end else if (clear) begin
      // Only valid is dropped; stale tag/target/ctr are harmless once invalid.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (update_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
        if (update_taken) begin
          target_q[up_idx] <= update_target;
        end
      end else if (update_taken) begin
        // Taken miss evicts whatever occupies the slot and starts weakly taken.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= WT;
      end
    end
  end

  // Statistics saturate instead of wrapping so long perf runs stay monotonic.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lookup_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (lookup_en && (lookup_count != 32'hFFFF_FFFF)) begin
        lookup_count <= lookup_count + 32'd1;
      end
      if (update_en && update_mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a behavioural table model and literal pins.
// Latency: checks combinational lookup each cycle at the falling edge.
// Backpressure: n/a.
module tb_branch_predictor;

  localparam int NE = 16;

  logic        CLK;
  logic        nRST;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        clear;
  logic [31:0] lookup_count;
  logic [31:0] mispredict_count;

  branch_predictor dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .lookup_en         (lookup_en),
    .lookup_pc         (lookup_pc),
    .predict_taken     (predict_taken),
    .predict_target    (predict_target),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .clear             (clear),
    .lookup_count      (lookup_count),
    .mispredict_count  (mispredict_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: each slot remembers the full word address of its owner.
  bit          m_valid [NE];
  logic [29:0] m_owner [NE];
  logic [31:0] m_tgt   [NE];
  int          m_ctr   [NE];
  longint      m_lc, m_mc;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % NE);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 0;
    end
    m_lc = 0;
    m_mc = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
    int s;
    s   = slot(pc);
    tk  = m_valid[s] && (m_owner[s] == pc[31:2]) && (m_ctr[s] >= 2);
    tgt = tk ? m_tgt[s] : pc + 32'd4;
  endtask

  task automatic model_update();
    int s;
    if (nRST !== 1'b1) return;
    if (lookup_en && m_lc < 64'hFFFF_FFFF) m_lc++;
    if (update_en && update_mispredict && m_mc < 64'hFFFF_FFFF) m_mc++;
    if (clear) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    end else if (update_en) begin
      s = slot(update_pc);
      if (m_valid[s] && m_owner[s] == update_pc[31:2]) begin
        if (update_taken) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = update_target;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (update_taken) begin
        m_valid[s] = 1'b1;
        m_owner[s] = update_pc[31:2];
        m_tgt[s]   = update_target;
        m_ctr[s]   = 2;
      end
    end
  endtask

  task automatic compare_all();
    logic        etk;
    logic [31:0] etgt;
    model_predict(lookup_pc, etk, etgt);
    chk("predict_taken", 32'(predict_taken), 32'(etk));
    chk("predict_target", predict_target, etgt);
    chk("lookup_count", lookup_count, m_lc[31:0]);
    chk("mispredict_count", mispredict_count, m_mc[31:0]);
  endtask

  // One cycle: compare at the falling edge, advance model at the rising edge.
  task automatic tick();
    @(negedge CLK);
    compare_all();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic drive(input logic le, input logic [31:0] lpc, input logic ue,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                       input logic um, input logic cl);
    lookup_en         = le;
    lookup_pc         = lpc;
    update_en         = ue;
    update_pc         = upc;
    update_taken      = ut;
    update_target     = utg;
    update_mispredict = um;
    clear             = cl;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mis);
    drive(1'b0, 32'h0, 1'b1, pc, tk, tgt, mis, 1'b0);
    tick();
  endtask

  // Lookup-only cycle with literal expectations checked before the edge.
  task automatic probe(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("lit_taken", 32'(predict_taken), 32'(tk));
    chk("lit_target", predict_target, tgt);
    tick();
  endtask

  // Stats pattern: {update_en, update_mispredict} for five lookup cycles.
  logic [1:0] stat_pat [5] = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b00};

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    #1;
    tick();
    tick();
    nRST = 1'b1;

    // Reset state.
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_taken", 32'(predict_taken), 32'h0);
    chk("rst_target", predict_target, 32'h44);
    chk("rst_lookup_count", lookup_count, 32'h0);
    chk("rst_mispredict_count", mispredict_count, 32'h0);
    tick();

    // Allocation and counter walk.
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    probe(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    probe(32'h40, 1'b0, 32'h44);
    repeat (4) upd(32'h40, 1'b1, 32'h100, 1'b0);
    probe(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    probe(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    probe(32'h40, 1'b0, 32'h44);

    // X on ignored update inputs must not disturb the table.
    drive(1'b1, 32'h40, 1'b0, 'x, 'x, 'x, 'x, 1'b0);
    tick();
    probe(32'h40, 1'b0, 32'h44);

    // Aliasing on index 0, unallocated not-taken update, pc+4 wrap.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    probe(32'h40, 1'b0, 32'h44);
    probe(32'h80, 1'b1, 32'h200);
    upd(32'h1004, 1'b0, 32'h0, 1'b0);
    probe(32'h1004, 1'b0, 32'h1008);
    probe(32'hFFFF_FFFC, 1'b0, 32'h0);

    // Same-cycle lookup/update: no bypass.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 1'b0);
    #1;
    chk("same_cycle_target", predict_target, 32'h44);
    tick();
    probe(32'h40, 1'b1, 32'h300);

    // clear beats a simultaneous update.
    drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h400, 1'b0, 1'b1);
    tick();
    probe(32'h40, 1'b0, 32'h44);
    probe(32'h80, 1'b0, 32'h84);

    // Asynchronous reset mid-run, observed with no clock edge.
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h500, 1'b1, 1'b0);
    tick();
    nRST = 1'b0;
    model_reset();
    #1;
    chk("async_rst_lookup_count", lookup_count, 32'h0);
    chk("async_rst_mispredict_count", mispredict_count, 32'h0);
    chk("async_rst_target", predict_target, 32'h44);
    tick();
    nRST = 1'b1;

    // Statistics: five lookups, three updates, two flagged mispredict.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h40, stat_pat[i][1], 32'h40, 1'b1, 32'h600, stat_pat[i][0], 1'b0);
      tick();
    end
    drive(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stat_lookup_count", lookup_count, 32'd5);
    chk("stat_mispredict_count", mispredict_count, 32'd2);
    tick();

    // Saturation of mispredict_count.
    force dut.mispredict_count = 32'hFFFF_FFFF;
    m_mc = 64'hFFFF_FFFF;
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    release dut.mispredict_count;
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    drive(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("sat_mispredict_count", mispredict_count, 32'hFFFF_FFFF);
    chk("sat_lookup_count", lookup_count, 32'd5);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
